// File: rtl/sigmoid_arbiter.sv
// sigmoid_arbiter: round-robin sharing of one pipelined sigmoid unit among
// N_REQ requesters. Each requester keeps at most one operation in flight,
// and its result is held in a per-requester register until it is consumed.
// Optional feature macro: SIGMOID_ARBITER_PERF_EN adds busy_cnt/grant_cnt.
module sigmoid_arbiter #(
    parameter int N_REQ   = 4,
    parameter int SIG_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [31*N_REQ-1:0]  req_x,
    output logic [N_REQ-1:0]     req_ready,
    output logic [30:0]          sig_x,
    input  logic [30:0]          sig_y,
    output logic [N_REQ-1:0]     resp_valid,
    output logic [31*N_REQ-1:0]  resp_y,
    input  logic [N_REQ-1:0]     resp_ready,
`ifdef SIGMOID_ARBITER_PERF_EN
    output logic [31:0]          busy_cnt,
    output logic [31:0]          grant_cnt,
`endif
    output logic [1:0]           state
);

    localparam int          PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned NR = N_REQ;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_DRAIN = 2'b10;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [PW-1:0]       r_ptr;
    logic [30:0]         r_sig_x;
    logic [N_REQ-1:0]    r_inflight;
    logic [N_REQ-1:0]    r_resp_valid;
    logic [31*N_REQ-1:0] r_resp_y;
    logic [SIG_LAT:0]    r_pipe_v;
    logic [PW-1:0]       r_pipe_tag [SIG_LAT+1];

    logic [N_REQ-1:0]    w_elig;
    logic [N_REQ-1:0]    w_grant;
    logic                w_grant_any;
    logic [PW-1:0]       w_win;
    logic [PW:0]         w_sum;
    logic [PW-1:0]       w_idx;
    logic                w_cap;
    logic [PW-1:0]       w_cap_tag;
    logic [N_REQ-1:0]    w_cap_onehot;

    // Eligibility: RUN only, no held result, nothing already in flight
    always_comb begin
        w_elig = '0;
        if (r_state == ST_RUN) begin
            w_elig = req_valid & ~r_resp_valid & ~r_inflight;
        end
    end

    // Round-robin search starting one past the last granted requester
    always_comb begin
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_win       = r_ptr;
        w_sum       = '0;
        w_idx       = '0;
        for (int unsigned k = 1; k <= NR; k++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NR)) begin
                w_sum = w_sum - (PW+1)'(NR);
            end
            w_idx = w_sum[PW-1:0];
            if (!w_grant_any && w_elig[w_idx]) begin
                w_grant_any = 1'b1;
                w_win       = w_idx;
            end
        end
        if (w_grant_any) begin
            w_grant[w_win] = 1'b1;
        end
    end

    // Tail of the tag pipeline marks the cycle in which sig_y belongs to tag
    always_comb begin
        w_cap        = r_pipe_v[SIG_LAT];
        w_cap_tag    = r_pipe_tag[SIG_LAT];
        w_cap_onehot = '0;
        if (w_cap) begin
            w_cap_onehot[w_cap_tag] = 1'b1;
        end
    end

    // FSM next state; a grant on the exit edge counts as in flight so the
    // block passes through DRAIN until that result is captured
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!en) begin
                    w_state_nxt = ((r_inflight | w_grant) != '0) ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (en) begin
                    w_state_nxt = ST_RUN;
                end else if (r_inflight == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand register and round-robin pointer, updated only on a grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= PW'(N_REQ - 1);
            r_sig_x <= '0;
        end else if (w_grant_any) begin
            r_ptr   <= w_win;
            r_sig_x <= req_x[31*w_win +: 31];
        end
    end

    // Tag pipeline shifts every cycle so captures continue in any state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pipe_v <= '0;
            for (int unsigned s = 0; s <= SIG_LAT; s++) begin
                r_pipe_tag[s] <= '0;
            end
        end else begin
            r_pipe_v[0]   <= w_grant_any;
            r_pipe_tag[0] <= w_win;
            for (int unsigned s = 1; s <= SIG_LAT; s++) begin
                r_pipe_v[s]   <= r_pipe_v[s-1];
                r_pipe_tag[s] <= r_pipe_tag[s-1];
            end
        end
    end

    // In-flight and result-valid flags; set and clear never hit the same bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight   <= '0;
            r_resp_valid <= '0;
        end else begin
            r_inflight   <= (r_inflight | w_grant) & ~w_cap_onehot;
            r_resp_valid <= (r_resp_valid & ~(r_resp_valid & resp_ready)) | w_cap_onehot;
        end
    end

    // Result registers capture sig_y unmodified into the tagged slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resp_y <= '0;
        end else if (w_cap) begin
            r_resp_y[31*w_cap_tag +: 31] <= sig_y;
        end
    end

`ifdef SIGMOID_ARBITER_PERF_EN
    logic [31:0] r_busy_cnt;
    logic [31:0] r_grant_cnt;

    // Saturating busy-cycle and accepted-operand counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy_cnt  <= '0;
            r_grant_cnt <= '0;
        end else begin
            if ((r_inflight != '0) && (r_busy_cnt != '1)) begin
                r_busy_cnt <= r_busy_cnt + 32'd1;
            end
            if (w_grant_any && (r_grant_cnt != '1)) begin
                r_grant_cnt <= r_grant_cnt + 32'd1;
            end
        end
    end

    assign busy_cnt  = r_busy_cnt;
    assign grant_cnt = r_grant_cnt;
`endif

    assign req_ready  = w_grant;
    assign sig_x      = r_sig_x;
    assign resp_valid = r_resp_valid;
    assign resp_y     = r_resp_y;
    assign state      = r_state;

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Testbench for sigmoid_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model (pending-result queue
// keyed by due edge). Define SIGMOID_ARBITER_PERF_EN to include counter checks.
module tb_sigmoid_arbiter;

    localparam int N   = 4;
    localparam int LAT = 1;
    localparam logic [30:0] SIG_OFS = 31'd50000000;

    logic            clk = 1'b0;
    logic            reset;
    logic            en;
    logic [N-1:0]    req_valid;
    logic [31*N-1:0] req_x;
    logic [N-1:0]    req_ready;
    logic [30:0]     sig_x;
    logic [30:0]     sig_y;
    logic [N-1:0]    resp_valid;
    logic [31*N-1:0] resp_y;
    logic [N-1:0]    resp_ready;
    logic [1:0]      state;
`ifdef SIGMOID_ARBITER_PERF_EN
    logic [31:0]     busy_cnt;
    logic [31:0]     grant_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sigmoid_arbiter #(.N_REQ(N), .SIG_LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_ready  (req_ready),
        .sig_x      (sig_x),
        .sig_y      (sig_y),
        .resp_valid (resp_valid),
        .resp_y     (resp_y),
        .resp_ready (resp_ready),
`ifdef SIGMOID_ARBITER_PERF_EN
        .busy_cnt   (busy_cnt),
        .grant_cnt  (grant_cnt),
`endif
        .state      (state)
    );

    // Stand-in sigmoid unit: LAT register stages, y = x + 0.5 (scaled)
    logic [30:0] r_sy [LAT];
    always @(posedge clk) begin
        r_sy[0] <= sig_x + SIG_OFS;
        for (int s = 1; s < LAT; s++) r_sy[s] <= r_sy[s-1];
    end
    assign sig_y = r_sy[LAT-1];

    function automatic logic [30:0] sig_ref(input logic [30:0] x);
        return x + SIG_OFS;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int          tag;
        int          due;
        logic [30:0] y;
    } pend_t;

    int          m_state;
    int          m_ptr;
    int          m_edge;
    bit          m_rv   [N];
    bit          m_busy [N];
    logic [30:0] m_ry   [N];
    logic [30:0] m_sigx;
    logic [31:0] m_busy_cnt;
    logic [31:0] m_grant_cnt;
    pend_t       m_q [$];

    task automatic model_reset();
        m_state = 0;
        m_ptr   = N - 1;
        m_edge  = 0;
        for (int i = 0; i < N; i++) begin
            m_rv[i] = 0; m_busy[i] = 0; m_ry[i] = '0;
        end
        m_sigx      = '0;
        m_busy_cnt  = '0;
        m_grant_cnt = '0;
        m_q.delete();
    endtask

    function automatic int model_pick();
        int i;
        if (m_state != 1) return -1;
        for (int k = 1; k <= N; k++) begin
            i = (m_ptr + k) % N;
            if (req_valid[i] && !m_rv[i] && !m_busy[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = model_pick();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [N-1:0] pack_rv();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_rv[i];
        return r;
    endfunction

    function automatic logic [31*N-1:0] pack_ry();
        logic [31*N-1:0] r;
        for (int i = 0; i < N; i++) r[31*i +: 31] = m_ry[i];
        return r;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_step();
        int          g;
        bit          any_busy;
        bit          cap  [N];
        logic [30:0] capy [N];
        pend_t       keep [$];
        pend_t       p;
        g = model_pick();
        any_busy = 0;
        for (int i = 0; i < N; i++) if (m_busy[i]) any_busy = 1;
        if (any_busy && m_busy_cnt != '1) m_busy_cnt = m_busy_cnt + 1;
        if (g >= 0 && m_grant_cnt != '1) m_grant_cnt = m_grant_cnt + 1;
        m_edge++;
        for (int i = 0; i < N; i++) begin cap[i] = 0; capy[i] = '0; end
        foreach (m_q[j]) begin
            if (m_q[j].due == m_edge) begin
                cap[m_q[j].tag]  = 1;
                capy[m_q[j].tag] = m_q[j].y;
            end else begin
                keep.push_back(m_q[j]);
            end
        end
        m_q = keep;
        for (int i = 0; i < N; i++) begin
            if (cap[i]) begin
                m_rv[i] = 1; m_ry[i] = capy[i]; m_busy[i] = 0;
            end else if (m_rv[i] && resp_ready[i]) begin
                m_rv[i] = 0;
            end
        end
        case (m_state)
            0: if (en) m_state = 1;
            1: if (!en) m_state = (any_busy || g >= 0) ? 2 : 0;
            2: if (en) m_state = 1; else if (!any_busy) m_state = 0;
            default: m_state = 0;
        endcase
        if (g >= 0) begin
            m_busy[g] = 1;
            m_ptr     = g;
            m_sigx    = req_x[31*g +: 31];
            p.tag = g;
            p.due = m_edge + LAT + 1;
            p.y   = sig_ref(m_sigx);
            m_q.push_back(p);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; req_valid = '0; req_x = '0; resp_ready = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic randomize_x();
        for (int i = 0; i < N; i++) req_x[31*i +: 31] = 31'($urandom());
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; en = 1'b0; req_valid = '0; req_x = '0; resp_ready = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b expected 00", state); end
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        n_checks++; if (resp_valid !== '0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        n_checks++; if (resp_y !== '0) begin n_fail++; $display("FAIL reset_resp_y: got %h expected 0", resp_y); end
        n_checks++; if (sig_x !== '0) begin n_fail++; $display("FAIL reset_sig_x: got %h expected 0", sig_x); end
        en = 1'b1; req_valid = '1;
        @(posedge clk); #1;
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_hold_state: got %b expected 00", state); end
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_hold_ready: got %b expected 0", req_ready); end
    endtask

    task automatic test_single();
        do_reset();
        en = 1'b1; req_valid = 4'b0001; req_x = '0; resp_ready = '0;
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_idle_ready: got %b expected 0000", req_ready); end
        tick();
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL single_run_state: got %b expected 01", state); end
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_first_grant: got %b expected 0001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        n_checks++; if (sig_x !== 31'd0) begin n_fail++; $display("FAIL single_sig_x: got %h expected 0", sig_x); end
        n_checks++; if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_resp_e1: got %b expected 0000", resp_valid); end
        tick();
        n_checks++; if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_resp_e2: got %b expected 0000", resp_valid); end
        tick();
        n_checks++; if (resp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_resp_rise: got %b expected 0001", resp_valid); end
        n_checks++; if (resp_y[30:0] !== 31'd50000000) begin n_fail++; $display("FAIL single_resp_y: got %0d expected 50000000", resp_y[30:0]); end
        resp_ready = 4'b0001;
        tick();
        resp_ready = '0;
        n_checks++; if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_consume: got %b expected 0000", resp_valid); end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_g;
        do_reset();
        en = 1'b1; req_valid = '1; resp_ready = '1;
        randomize_x();
        tick();
        for (int k = 0; k < 12; k++) begin
            randomize_x();
            #1;
            exp_g = '0;
            exp_g[k % N] = 1'b1;
            n_checks++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL fair_cycle%0d: got %b expected %b", k, req_ready, exp_g); end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int cnt [N];
        logic [N-1:0] exp_g;
        do_reset();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        en = 1'b1; req_valid = '1; resp_ready = 4'b1011;
        tick();
        for (int k = 0; k < 24; k++) begin
            randomize_x();
            #1;
            exp_g = model_ready();
            n_checks++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL bp_grant_cycle%0d: got %b expected %b", k, req_ready, exp_g); end
            for (int i = 0; i < N; i++) if (req_ready[i]) cnt[i]++;
            tick();
        end
        n_checks++; if (cnt[2] != 1) begin n_fail++; $display("FAIL bp_r2_grants: got %0d expected 1", cnt[2]); end
        n_checks++; if (cnt[0] != 6 || cnt[1] != 6 || cnt[3] != 6) begin n_fail++; $display("FAIL bp_others: got %0d/%0d/%0d expected 6/6/6", cnt[0], cnt[1], cnt[3]); end
        req_valid = 4'b0100;
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_blocked: got %b expected 0000", req_ready); end
        tick();
        resp_ready = 4'b1111;
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_pulse_cycle: got %b expected 0000", req_ready); end
        tick();
        resp_ready = 4'b1011;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_resume: got %b expected 0100", req_ready); end
        tick();
        req_valid = '0; resp_ready = '1;
        repeat (4) tick();
    endtask

    task automatic test_drain();
        logic [1:0]   exp_st [4];
        logic [N-1:0] exp_rv [4];
        logic [30:0]  x0;
        logic [30:0]  x1;
        exp_st = '{2'b01, 2'b10, 2'b10, 2'b00};
        exp_rv = '{4'b0000, 4'b0001, 4'b0011, 4'b0011};
        do_reset();
        x0 = 31'($urandom()); x1 = 31'($urandom());
        req_x = '0; req_x[30:0] = x0; req_x[61:31] = x1;
        en = 1'b1; req_valid = 4'b0011; resp_ready = '0;
        tick();
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL drain_grant0: got %b expected 0001", req_ready); end
        tick();
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL drain_grant1: got %b expected 0010", req_ready); end
        tick();
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (state !== exp_st[k]) begin n_fail++; $display("FAIL drain_state%0d: got %b expected %b", k, state, exp_st[k]); end
            n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL drain_ready%0d: got %b expected 0000", k, req_ready); end
            n_checks++; if (resp_valid !== exp_rv[k]) begin n_fail++; $display("FAIL drain_resp_valid%0d: got %b expected %b", k, resp_valid, exp_rv[k]); end
            tick();
        end
        n_checks++; if (resp_y[30:0] !== sig_ref(x0)) begin n_fail++; $display("FAIL drain_y0: got %h expected %h", resp_y[30:0], sig_ref(x0)); end
        n_checks++; if (resp_y[61:31] !== sig_ref(x1)) begin n_fail++; $display("FAIL drain_y1: got %h expected %h", resp_y[61:31], sig_ref(x1)); end
    endtask

    task automatic test_reset_midop();
        logic [30:0] x;
        do_reset();
        x = 31'($urandom()) | 31'd1;
        req_x = '0; req_x[30:0] = x;
        en = 1'b1; req_valid = 4'b0001; resp_ready = '0;
        tick();
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_pre_grant: got %b expected 0001", req_ready); end
        tick();
        n_checks++; if (sig_x !== x) begin n_fail++; $display("FAIL rst_sigx_loaded: got %h expected %h", sig_x, x); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL rst_async_state: got %b expected 00", state); end
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL rst_async_ready: got %b expected 0", req_ready); end
        n_checks++; if (resp_valid !== '0) begin n_fail++; $display("FAIL rst_async_resp_valid: got %b expected 0", resp_valid); end
        n_checks++; if (resp_y !== '0) begin n_fail++; $display("FAIL rst_async_resp_y: got %h expected 0", resp_y); end
        n_checks++; if (sig_x !== '0) begin n_fail++; $display("FAIL rst_async_sig_x: got %h expected 0", sig_x); end
        req_valid = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            #1;
            n_checks++; if (resp_valid !== '0) begin n_fail++; $display("FAIL rst_no_resp%0d: got %b expected 0", k, resp_valid); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_g;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            en         = ($urandom_range(0, 7) != 0);
            req_valid  = N'($urandom());
            resp_ready = N'($urandom());
            randomize_x();
            #1;
            exp_g = model_ready();
            n_checks++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL rnd_ready%0d: got %b expected %b", k, req_ready, exp_g); end
            n_checks++; if (state !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state%0d: got %b expected %0d", k, state, m_state); end
            n_checks++; if (resp_valid !== pack_rv()) begin n_fail++; $display("FAIL rnd_resp_valid%0d: got %b expected %b", k, resp_valid, pack_rv()); end
            n_checks++; if (resp_y !== pack_ry()) begin n_fail++; $display("FAIL rnd_resp_y%0d: got %h expected %h", k, resp_y, pack_ry()); end
            n_checks++; if (sig_x !== m_sigx) begin n_fail++; $display("FAIL rnd_sig_x%0d: got %h expected %h", k, sig_x, m_sigx); end
            tick();
        end
    endtask

`ifdef SIGMOID_ARBITER_PERF_EN
    task automatic test_perf();
        int ng;
        int k;
        do_reset();
        en = 1'b1; req_valid = '1; resp_ready = '1;
        tick();
        ng = 0;
        k  = 0;
        while (ng < 10 && k < 60) begin
            randomize_x();
            #1;
            if (req_ready != '0) ng++;
            tick();
            k++;
        end
        req_valid = '0;
        n_checks++; if (ng != 10) begin n_fail++; $display("FAIL perf_grant_budget: got %0d grants expected 10", ng); end
        repeat (4) tick();
        n_checks++; if (grant_cnt !== 32'd10) begin n_fail++; $display("FAIL perf_grant_cnt: got %0d expected 10", grant_cnt); end
        n_checks++; if (busy_cnt !== m_busy_cnt) begin n_fail++; $display("FAIL perf_busy_cnt: got %0d expected %0d", busy_cnt, m_busy_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_drain();
        test_reset_midop();
        test_random();
`ifdef SIGMOID_ARBITER_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
